// File: rtl/vslc_pkg.sv
// Shared decode and state definitions for the VSLC executor and scan sequencer.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
package vslc_pkg;

  // Sequencer FSM encoding.
  typedef logic [2:0] seq_state_t;
  localparam seq_state_t ST_IDLE  = 3'd0;
  localparam seq_state_t ST_SNAP  = 3'd1;
  localparam seq_state_t ST_FETCH = 3'd2;
  localparam seq_state_t ST_ISSUE = 3'd3;
  localparam seq_state_t ST_PARAM = 3'd4;
  localparam seq_state_t ST_END   = 3'd5;
  localparam seq_state_t ST_FAULT = 3'd6;

  // Set-parameter opcodes carry one trailing parameter byte.
  localparam logic [7:0] OPC_SPARAM_MASK = 8'hF0;
  localparam logic [7:0] OPC_SPARAM      = 8'hE0;

  // Opcode classes (upper nibble), shared with the executor decoder.
  localparam logic [3:0] OPC_CLS_LOGIC  = 4'h0;
  localparam logic [3:0] OPC_CLS_TIMER  = 4'h4;
  localparam logic [3:0] OPC_CLS_SERVO  = 4'h9;
  localparam logic [3:0] OPC_CLS_SPARAM = 4'hE;

  function automatic logic is_sparam(input logic [7:0] opc);
    return (opc & OPC_SPARAM_MASK) == OPC_SPARAM;
  endfunction

endpackage

// File: rtl/vslc_prefetch_fifo.sv
// Two-entry byte FIFO holding prefetched program bytes; entry 0 is the head.
// Latency: a pushed byte is visible on head the cycle after the push.
// Backpressure: push ignored when full (unless popping), pop ignored when empty.
module vslc_prefetch_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  logic [7:0] ent0;
  logic [7:0] ent1;

  assign head  = ent0;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  // Shift-style storage: popping moves entry 1 to the head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent0  <= 8'h00;
      ent1  <= 8'h00;
      count <= 2'd0;
    end else begin
      if (push && pop && !empty) begin
        if (count == 2'd2) begin
          ent0 <= ent1;
          ent1 <= push_data;
        end else begin
          ent0 <= push_data;
        end
      end else if (push && !full) begin
        if (empty) ent0 <= push_data;
        else       ent1 <= push_data;
        count <= count + 2'd1;
      end else if (pop && !empty) begin
        ent0  <= ent1;
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: rtl/vslc_scan_sequencer.sv
// PLC scan scheduler: snapshots inputs, prefetches the program and strobes opcodes to the executor.
// Latency: at most one opcode strobe every 2 cycles; set-parameter bytes follow their opcode directly.
// Backpressure: memory side stalls while the prefetch FIFO is full; a stalled read faults after MEM_TIMEOUT.
module vslc_scan_sequencer
  import vslc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MEM_TIMEOUT = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] prog_len,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [7:0]        mem_data,
  output logic [7:0]        instr,
  output logic              instr_ready,
  input  logic [7:0]        ui_in,
  output logic [7:0]        ui_scan,
  output logic [7:0]        ui_scan_prev,
  output logic [15:0]       counter,
  output logic              scan_done,
  output logic              busy,
  output logic              fault
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  seq_state_t        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] fetch_addr;
  logic [TO_W-1:0]   wait_cnt;
  logic [7:0]        sync_q [SYNC_STAGES];

  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic [1:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;

  logic prog_done;
  logic head_sparam;
  logic last_byte;
  logic timeout;
  logic go_fault;
  logic go_issue;

  assign mem_req     = (state == ST_FETCH) && !fifo_full && (fetch_addr < len);
  assign mem_addr    = fetch_addr;
  assign fifo_push   = mem_req && mem_valid;
  assign instr_ready = (state == ST_ISSUE);
  assign scan_done   = (state == ST_END);
  assign fault       = (state == ST_FAULT);
  assign busy        = (state != ST_IDLE) && (state != ST_FAULT);

  // Issue decision in FETCH: an opcode only leaves once everything it needs is buffered.
  assign prog_done   = (pc == len);
  assign head_sparam = is_sparam(fifo_head);
  assign last_byte   = (pc == len - ADDR_W'(1));
  assign timeout     = mem_req && !mem_valid && (wait_cnt == TO_W'(MEM_TIMEOUT - 1));
  assign go_fault    = timeout || (!prog_done && !fifo_empty && head_sparam && last_byte);
  assign go_issue    = !prog_done && !fifo_empty && (!head_sparam || fifo_count == 2'd2);
  assign fifo_pop    = ((state == ST_FETCH) && !go_fault && go_issue) ||
                       ((state == ST_ISSUE) && is_sparam(instr));

  vslc_prefetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (mem_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Free-running divider base for the executor, independent of scan state.
  always_ff @(posedge clk) begin
    if (!rst_n) counter <= 16'h0000;
    else        counter <= counter + 16'h0001;
  end

  // Input synchroniser chain for the asynchronous ui_in pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
    end else begin
      sync_q[0] <= ui_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Scan FSM, fetch address and stalled-read watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pc           <= '0;
      len          <= '0;
      fetch_addr   <= '0;
      wait_cnt     <= '0;
      instr        <= 8'h00;
      ui_scan      <= 8'h00;
      ui_scan_prev <= 8'h00;
    end else begin
      if (mem_req && !mem_valid) wait_cnt <= wait_cnt + TO_W'(1);
      else                       wait_cnt <= '0;
      if (fifo_push) fetch_addr <= fetch_addr + ADDR_W'(1);

      case (state)
        ST_IDLE: if (run) state <= ST_SNAP;
        ST_SNAP: begin
          ui_scan_prev <= ui_scan;
          ui_scan      <= sync_q[SYNC_STAGES-1];
          pc           <= '0;
          len          <= prog_len;
          fetch_addr   <= '0;
          state        <= ST_FETCH;
        end
        ST_FETCH: begin
          if (go_fault) begin
            state <= ST_FAULT;
          end else if (prog_done) begin
            state <= ST_END;
          end else if (go_issue) begin
            instr <= fifo_head;
            pc    <= pc + ADDR_W'(1);
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (is_sparam(instr)) begin
            instr <= fifo_head;
            pc    <= pc + ADDR_W'(1);
            state <= ST_PARAM;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_PARAM: state <= ST_FETCH;
        ST_END:   state <= run ? ST_SNAP : ST_IDLE;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Randomized self-checking bench for the scan sequencer against a list-level program model.
// Latency: memory responder answers after 1..3 request cycles.
// Backpressure: responder can be stalled to exercise the read watchdog.
module tb_vslc_scan_sequencer;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  prog_len = 8'h00;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_valid = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  instr;
  logic        instr_ready;
  logic [7:0]  ui_in = 8'h00;
  logic [7:0]  ui_scan;
  logic [7:0]  ui_scan_prev;
  logic [15:0] counter;
  logic        scan_done;
  logic        busy;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [7:0] prog [256];
  logic [7:0] last_ui = 8'h00;
  bit         stall = 1'b0;
  int         lat = 1;
  int         wcnt = 0;

  vslc_scan_sequencer #(.ADDR_W(8), .MEM_TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .prog_len     (prog_len),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .ui_in        (ui_in),
    .ui_scan      (ui_scan),
    .ui_scan_prev (ui_scan_prev),
    .counter      (counter),
    .scan_done    (scan_done),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  // Program memory: answers a held request after lat cycles; emits stray valids while idle.
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (mem_req) begin
      if (!stall && wcnt >= lat) begin
        mem_valid = 1'b1;
        mem_data  = prog[mem_addr];
        wcnt      = 0;
        lat       = $urandom_range(1, 3);
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
      if ($urandom_range(0, 3) == 0) begin
        mem_valid = 1'b1;
        mem_data  = 8'($urandom);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {11'd0, mem_req, mem_addr, instr, instr_ready, ui_scan, ui_scan_prev,
            counter, scan_done, busy, fault};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    last_ui = 8'h00;
  endtask

  // One scan of prog[0..n-1]; expected strobes derived from the program listing.
  task automatic run_scan(input int n, input logic [7:0] ui);
    logic [7:0] exp_ops[$];
    int         exp_par[$];
    logic [7:0] got_ops[$];
    int         got_par[$];
    bit         exp_fault = 1'b0;
    bit         pend_par = 1'b0;
    bit         prev_rdy = 1'b0;
    bit         b2b = 1'b0;
    bit         ui_bad = 1'b0;
    bit         ended = 1'b0;
    int         i = 0;
    while (i < n) begin
      if ((prog[i] & 8'hF0) == 8'hE0) begin
        if (i == n - 1) begin
          exp_fault = 1'b1;
          break;
        end
        exp_ops.push_back(prog[i]);
        exp_par.push_back(int'(prog[i+1]));
        i += 2;
      end else begin
        exp_ops.push_back(prog[i]);
        exp_par.push_back(-1);
        i += 1;
      end
    end

    ui_in    = ui;
    prog_len = 8'(n);
    repeat (4) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    prog_len = 8'($urandom);
    ui_in    = 8'($urandom);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (ui_scan !== ui || ui_scan_prev !== last_ui) ui_bad = 1'b1;
      if (pend_par) begin
        got_par.push_back(instr_ready ? 999 : int'(instr));
        pend_par = 1'b0;
      end
      if (instr_ready) begin
        if (prev_rdy) b2b = 1'b1;
        got_ops.push_back(instr);
        if ((instr & 8'hF0) == 8'hE0) pend_par = 1'b1;
        else got_par.push_back(-1);
      end
      prev_rdy = instr_ready;
      if (scan_done || fault) begin
        ended = 1'b1;
        break;
      end
    end
    check("scan_ended", 64'(ended), 64'd1);
    check("op_count", 64'(got_ops.size()), 64'(exp_ops.size()));
    for (int k = 0; k < exp_ops.size() && k < got_ops.size(); k++) begin
      check($sformatf("op%0d", k), 64'(got_ops[k]), 64'(exp_ops[k]));
      if (k < got_par.size()) check($sformatf("par%0d", k), 64'(got_par[k]), 64'(exp_par[k]));
    end
    check("no_b2b_strobe", 64'(b2b), 64'd0);
    check("fault", 64'(fault), 64'(exp_fault));
    if (exp_fault) begin
      check("fault_quiet", {62'd0, mem_req, instr_ready}, 64'd0);
      check("fault_not_busy", 64'(busy), 64'd0);
      do_reset();
    end else begin
      check("ui_stable", 64'(ui_bad), 64'd0);
      check("ui_scan", 64'(ui_scan), 64'(ui));
      check("ui_scan_prev", 64'(ui_scan_prev), 64'(last_ui));
      check("busy_at_end", 64'(busy), 64'd1);
      @(negedge clk);
      check("idle_after_stop", {62'd0, busy, scan_done}, 64'd0);
      last_ui = ui;
    end
  endtask

  initial begin
    int rise;
    int done_cyc[$];
    bit saw_req;
    bit got_fault;

    for (int a = 0; a < 256; a++) prog[a] = 8'h00;

    // Reset state and counter wrap.
    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);
    rst_n = 1'b1;
    check("cnt_start", 64'(counter), 64'd0);
    repeat (100) @(negedge clk);
    check("cnt_100", 64'(counter), 64'd100);
    repeat (65435) @(negedge clk);
    check("cnt_ffff", 64'(counter), 64'hFFFF);
    @(negedge clk);
    check("cnt_wrap", 64'(counter), 64'h0000);

    // Linear program, then set-parameter program with a second snapshot.
    prog[0] = 8'h00; prog[1] = 8'h41; prog[2] = 8'h93;
    run_scan(3, 8'h05);
    prog[0] = 8'hE9; prog[1] = 8'h2A; prog[2] = 8'h10;
    run_scan(3, 8'h07);
    prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03; prog[3] = 8'h04;
    run_scan(4, 8'hA5);

    // Randomized programs, biased toward set-parameter opcodes.
    for (int s = 0; s < 12; s++) begin
      int n = $urandom_range(1, 16);
      for (int a = 0; a < n; a++)
        prog[a] = ($urandom_range(0, 2) == 0) ? (8'hE0 | 8'($urandom_range(0, 15))) : 8'($urandom);
      run_scan(n, 8'($urandom));
    end

    // Set-parameter opcode with no parameter byte.
    prog[0] = 8'h11; prog[1] = 8'hE3;
    run_scan(2, 8'h3C);

    // Stalled memory read trips the watchdog.
    stall    = 1'b1;
    prog_len = 8'd5;
    run      = 1'b1;
    rise     = -1;
    got_fault = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (rise < 0 && mem_req) rise = c;
      if (fault) begin
        check("timeout_cycles", 64'(c - rise), 64'(TIMEOUT));
        got_fault = 1'b1;
        break;
      end
    end
    check("timeout_fault", 64'(got_fault), 64'd1);
    check("timeout_req_low", 64'(mem_req), 64'd0);
    stall = 1'b0;
    do_reset();

    // Empty program with run held: back-to-back scans, no memory traffic.
    prog_len = 8'd0;
    run      = 1'b1;
    saw_req  = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_req) saw_req = 1'b1;
      if (scan_done) done_cyc.push_back(c);
    end
    run = 1'b0;
    check("empty_no_req", 64'(saw_req), 64'd0);
    check("empty_done_count", 64'(done_cyc.size() >= 8), 64'd1);
    for (int k = 1; k < done_cyc.size(); k++)
      check($sformatf("empty_period%0d", k), 64'(done_cyc[k] - done_cyc[k-1]), 64'd3);
    repeat (4) @(negedge clk);
    check("empty_idle", 64'(busy), 64'd0);
    do_reset();

    // Reset during FETCH returns everything to zero.
    for (int a = 0; a < 8; a++) prog[a] = 8'(a + 1);
    ui_in    = 8'h5A;
    prog_len = 8'd8;
    repeat (4) @(negedge clk);
    run = 1'b1;
    saw_req = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mem_req) begin
        saw_req = 1'b1;
        break;
      end
    end
    check("midscan_fetch_seen", 64'(saw_req), 64'd1);
    rst_n = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    check("midscan_reset", out_vec(), 64'd0);
    rst_n   = 1'b1;
    last_ui = 8'h00;
    prog[0] = 8'hE1; prog[1] = 8'h77; prog[2] = 8'h22;
    run_scan(3, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
